// File: rtl/vram_arbiter.sv
// vram_arbiter: time-shares one single-port synchronous RAM between video fetch and CPU.
// Each access takes IDLE(grant) -> ISSUE -> DATA; video has priority, limited by a streak guard.
module vram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state  | meaning
  // IDLE   | arbitrate sampled requests, register RAM command on a grant
  // ISSUE  | RAM samples mem_addr/mem_we/mem_wdata
  // DATA   | mem_rdata valid; captured into the owner's rdata, owner acked
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_VID_STREAK);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_vid_streak;
  logic [3:0]        w_streak_nxt;
  logic              r_owner_cpu;
  logic              r_cpu_write;
  logic              w_grant_cpu;
  logic              w_grant_vid;
  logic              w_ack_vid;
  logic              w_ack_cpu;

  logic              r_vid_ack;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_vid_rdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_vid_streak <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_vid_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_vid_streak;
    w_grant_cpu  = 1'b0;
    w_grant_vid  = 1'b0;
    w_ack_vid    = 1'b0;
    w_ack_cpu    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req && (!vid_req || (r_vid_streak == LP_MAX_STREAK))) begin
          w_grant_cpu  = 1'b1;
          w_streak_nxt = 4'd0;
          w_state_nxt  = ST_ISSUE;
        end else if (vid_req) begin
          w_grant_vid = 1'b1;
          w_state_nxt = ST_ISSUE;
          // Streak only counts grants that made a waiting CPU wait longer.
          if (!cpu_req) begin
            w_streak_nxt = 4'd0;
          end else if (r_vid_streak != LP_MAX_STREAK) begin
            w_streak_nxt = r_vid_streak + 4'd1;
          end
        end else begin
          w_streak_nxt = 4'd0;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_ack_vid   = !r_owner_cpu;
        w_ack_cpu   = r_owner_cpu;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner_cpu <= 1'b0;
      r_cpu_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_rdata <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_vid_ack <= w_ack_vid;
      r_cpu_ack <= w_ack_cpu;
      if (w_grant_cpu) begin
        r_owner_cpu <= 1'b1;
        r_cpu_write <= cpu_we;
        r_mem_addr  <= cpu_addr;
        r_mem_we    <= cpu_we;
        r_mem_wdata <= cpu_wdata;
      end else if (w_grant_vid) begin
        r_owner_cpu <= 1'b0;
        r_cpu_write <= 1'b0;
        r_mem_addr  <= vid_addr;
        r_mem_we    <= 1'b0;
      end else if (r_state == ST_ISSUE) begin
        r_mem_we <= 1'b0;
      end
      if (w_ack_vid) begin
        r_vid_rdata <= mem_rdata;
      end
      if (w_ack_cpu && !r_cpu_write) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign vid_ack   = r_vid_ack;
  assign cpu_ack   = r_cpu_ack;
  assign vid_rdata = r_vid_rdata;
  assign cpu_rdata = r_cpu_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus, a RAM model, and a transaction-level reference
// model compared against every DUT output on every cycle after the first reset.
module tb_vram_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VID_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Synchronous single-port RAM: read data appears the cycle after the address.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  // Reference model: an access occupies the RAM for a fixed 3-cycle window; m_left counts
  // the edges until it is acknowledged. Read data comes from a shadow copy of memory.
  logic [DW-1:0] shadow [0:65535];
  bit            m_valid = 1'b0;
  int            m_left  = 0;
  int            m_streak = 0;
  bit            m_owner_cpu, m_write;
  logic [DW-1:0] m_data;
  logic          e_vid_ack, e_cpu_ack, e_mem_we, e_busy;
  logic [DW-1:0] e_vid_rdata, e_cpu_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;

  always @(posedge clk) begin
    cyc++;
    e_vid_ack = 1'b0;
    e_cpu_ack = 1'b0;
    if (!reset) begin
      m_valid = 1'b1;
      m_left = 0; m_streak = 0;
      e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
      e_vid_rdata = 0; e_cpu_rdata = 0;
    end else if (m_left == 2) begin
      m_left = 1;
      e_mem_we = 1'b0;
    end else if (m_left == 1) begin
      m_left = 0;
      if (m_owner_cpu) begin
        e_cpu_ack = 1'b1;
        if (!m_write) e_cpu_rdata = m_data;
      end else begin
        e_vid_ack = 1'b1;
        e_vid_rdata = m_data;
      end
    end else begin
      if (cpu_req && (!vid_req || m_streak == MAXS)) begin
        m_owner_cpu = 1'b1; m_write = cpu_we;
        e_mem_addr = cpu_addr; e_mem_we = cpu_we; e_mem_wdata = cpu_wdata;
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        else m_data = shadow[cpu_addr];
        m_streak = 0; m_left = 2;
      end else if (vid_req) begin
        m_owner_cpu = 1'b0; m_write = 1'b0;
        e_mem_addr = vid_addr; e_mem_we = 1'b0;
        m_data = shadow[vid_addr];
        m_streak = cpu_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        m_left = 2;
      end else begin
        m_streak = 0;
      end
    end
    e_busy = (m_left != 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("vid_ack", 32'(vid_ack), 32'(e_vid_ack));
      chk("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
      chk("vid_rdata", 32'(vid_rdata), 32'(e_vid_rdata));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
      chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
      chk("mem_we", 32'(mem_we), 32'(e_mem_we));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  // Observation bookkeeping for the hand-computed expectations.
  bit            s_prev_busy = 1'b0;
  int            s_rise_cyc  = 0;
  int            s_last_lat  = 0;
  int            s_busy_cnt  = 0;
  int            s_we_cnt    = 0;
  logic [AW-1:0] s_we_addr;
  logic [DW-1:0] s_we_data;
  string         s_seq;
  int            s_ack_cyc[$];

  task automatic step();
    @(negedge clk);
    if (busy && !s_prev_busy) s_rise_cyc = cyc;
    s_prev_busy = busy;
    if (busy) s_busy_cnt++;
    if (mem_we) begin
      s_we_cnt++;
      s_we_addr = mem_addr;
      s_we_data = mem_wdata;
    end
    if (vid_ack) begin
      s_seq = {s_seq, "V"};
      s_ack_cyc.push_back(cyc);
      s_last_lat = cyc - s_rise_cyc;
    end
    if (cpu_ack) begin
      s_seq = {s_seq, "C"};
      s_ack_cyc.push_back(cyc);
      s_last_lat = cyc - s_rise_cyc;
    end
  endtask

  task automatic wait_ack(input bit want_cpu, input int budget, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = want_cpu ? cpu_ack : vid_ack;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s timeout after %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_n_acks(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && s_ack_cyc.size() < n; i++) step();
    if (s_ack_cyc.size() < n) begin
      checks++; failures++;
      $display("FAIL %s timeout acks=%0d of %0d", nm, s_ack_cyc.size(), n);
    end
  endtask

  function automatic int bad_spacing();
    int bad = 0;
    for (int i = 1; i < s_ack_cyc.size(); i++)
      if (s_ack_cyc[i] - s_ack_cyc[i-1] != 3) bad++;
    return bad;
  endfunction

  initial begin
    int ncpu;
    reset = 1'b0; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    ram[16'h0040]    = 8'h3C;
    shadow[16'h0040] = 8'h3C;

    // Reset for 3 cycles, then idle
    repeat (3) step();
    chk("rst_outputs", {vid_ack, cpu_ack, mem_we, busy}, 4'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b1;
    s_we_cnt = 0; s_busy_cnt = 0;
    repeat (5) step();
    chk("idle_we_count", s_we_cnt, 0);
    chk("idle_busy_count", s_busy_cnt, 0);

    // CPU write then read-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
    wait_ack(1'b1, 20, "cpu_write_ack");
    cpu_req = 1'b0;
    chk("write_we_cycles", s_we_cnt, 1);
    chk("write_addr", 32'(s_we_addr), 32'h1234);
    chk("write_data", 32'(s_we_data), 32'hA5);
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 8'h00;
    wait_ack(1'b1, 20, "cpu_read_ack");
    cpu_req = 1'b0;
    chk("cpu_read_latency", s_last_lat, 2);
    chk("cpu_read_data", 32'(cpu_rdata), 32'hA5);
    chk("read_we_cycles", s_we_cnt, 1);

    // Video read with CPU idle
    step();
    vid_req = 1'b1; vid_addr = 16'h0040;
    wait_ack(1'b0, 20, "vid_read_ack");
    vid_req = 1'b0;
    chk("vid_read_latency", s_last_lat, 2);
    chk("vid_read_data", 32'(vid_rdata), 32'h3C);
    chk("cpu_rdata_held", 32'(cpu_rdata), 32'hA5);

    // Both requesters held: starvation guard lets the CPU in after 4 video grants
    repeat (2) step();
    s_seq = ""; s_ack_cyc.delete();
    vid_req = 1'b1; vid_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    wait_n_acks(10, 60, "contention_acks");
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (s_seq != "VVVVCVVVVC") begin
      failures++;
      $display("FAIL grant_order actual=%s required=VVVVCVVVVC", s_seq);
    end
    chk("contention_spacing", bad_spacing(), 0);

    // Reset during ISSUE of a CPU write abandons it; the held request is re-granted
    repeat (2) step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0777; cpu_wdata = 8'h5C;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("reached_issue", 32'(busy), 32'h1);
    reset = 1'b0;
    step();
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_no_ack", 32'(cpu_ack), 32'h0);
    step();
    chk("abort_no_ack2", 32'(cpu_ack), 32'h0);
    reset = 1'b1;
    wait_ack(1'b1, 20, "regrant_ack");
    cpu_req = 1'b0;
    chk("regrant_latency", s_last_lat, 2);
    step();
    chk("regrant_ram", 32'(ram[16'h0777]), 32'h5C);

    // Video streaming alone: back-to-back every 3 cycles
    step();
    s_seq = ""; s_ack_cyc.delete();
    vid_req = 1'b1; vid_addr = 16'h0040;
    wait_n_acks(20, 100, "stream_acks");
    vid_req = 1'b0;
    chk("stream_spacing", bad_spacing(), 0);
    ncpu = 0;
    for (int i = 0; i < s_seq.len(); i++) if (s_seq[i] == "C") ncpu++;
    chk("stream_no_cpu", ncpu, 0);
    chk("stream_vid_data", 32'(vid_rdata), 32'h3C);

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port synchronous video/work RAM between two requesters: the video fetch engine and the CPU. Runs entirely on masterclk. Grants one access at a time with a fixed 3-cycle access sequence. Video fetch has priority, bounded by a starvation guard so CPU accesses always complete. Sits between the clock/reset tree output and the RAM macro; the video and CPU cores connect through req/ack handshakes.

Parameters:
ADDR_W, 16, RAM address width.
DATA_W, 8, RAM data width.
MAX_VID_STREAK, 4, max consecutive video grants while cpu_req is pending; range 1..15.

Ports:
clk  input  1  masterclk; all logic on the rising edge.
reset  input  1  synchronous, active-low reset.
vid_req  input  1  video read request; held high until vid_ack.
vid_addr  input  ADDR_W  video read address; stable while vid_req is high.
vid_ack  output  1  one-cycle pulse: video access done, vid_rdata valid.
vid_rdata  output  DATA_W  video read data, registered, valid with vid_ack.
cpu_req  input  1  CPU request; held high until cpu_ack.
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_addr  input  ADDR_W  CPU address; stable while cpu_req is high.
cpu_wdata  input  DATA_W  CPU write data; stable while cpu_req is high.
cpu_ack  output  1  one-cycle pulse: CPU access done; cpu_rdata valid on reads.
cpu_rdata  output  DATA_W  CPU read data, registered, valid with cpu_ack (reads only).
mem_addr  output  ADDR_W  RAM address, registered.
mem_we  output  1  RAM write enable, registered.
mem_wdata  output  DATA_W  RAM write data, registered.
mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_addr is presented.
busy  output  1  high in ISSUE and DATA states.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, vid_streak=0. All outputs are 0: vid_ack, cpu_ack, vid_rdata, cpu_rdata, mem_addr, mem_we, mem_wdata, busy. An in-flight access is abandoned: no ack is issued, and mem_we is 0 from the next cycle.
- FSM states: IDLE, ISSUE, DATA. owner is a register: VID or CPU.
- IDLE: arbitrate on the sampled requests.
  - Grant CPU if cpu_req && (!vid_req || vid_streak==MAX_VID_STREAK).
  - Otherwise grant video if vid_req.
  - On a grant: register mem_addr, mem_we (cpu_we for CPU, 0 for video), mem_wdata (cpu_wdata for CPU, hold the old value for video), owner; then go to ISSUE.
  - With no request, stay in IDLE with mem_we=0.
- ISSUE: the RAM samples mem_addr/mem_we/mem_wdata. Go to DATA. mem_we is cleared at the end of ISSUE, so it is high for exactly 1 cycle per write.
- DATA: capture mem_rdata into vid_rdata (owner VID) or into cpu_rdata (owner CPU read). Pulse the owner's ack for this cycle only. Go to IDLE.
- Latency: a grant at edge t gives ack high in cycle t+2. Minimum spacing between grants is 3 cycles. The non-owner's rdata register holds its value.
- Handshake: a requester may drop req in the cycle ack is high, or keep it high to request again; a held req is re-arbitrated in the following IDLE cycle. A req deasserted before ack is a protocol violation; the accepted access still completes and acks.
- Starvation guard (vid_streak, 4 bits):
  - On a video grant with cpu_req high: increment, saturating at MAX_VID_STREAK.
  - On a CPU grant, or in any IDLE cycle with cpu_req low: clear to 0.
- Simultaneous requests at streak < MAX: video wins. At streak == MAX: CPU wins, then the streak clears.
- Address width is passed through unchanged; there are no address arithmetic or wrap effects.

Test Plan:
1. Reset low for 3 cycles, then high, with no requests -> all outputs 0, busy=0, mem_we never asserted.
2. CPU write addr 0x1234 data 0xA5, then CPU read of 0x1234 -> mem_we high for exactly 1 cycle with mem_addr=0x1234 and mem_wdata=0xA5; second cpu_ack 2 cycles after its grant with cpu_rdata=0xA5.
3. vid_req and cpu_req rise in the same cycle, both held high, MAX_VID_STREAK=4 -> grant order V,V,V,V,C,V,V,V,V,C; acks spaced 3 cycles apart.
4. Video read of 0x0040 (RAM holds 0x3C) while CPU is idle -> vid_ack 2 cycles after the grant, vid_rdata=0x3C, cpu_rdata unchanged.
5. Reset driven low during ISSUE of a CPU write -> no cpu_ack, mem_we=0 from the next edge, state IDLE; after reset release, the held cpu_req is re-granted and completes normally.
6. vid_req held continuously with no CPU traffic for 20 accesses -> vid_streak stays 0 and vid_ack pulses every 3 cycles.
